// File: rtl/dino_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dino_game_ctrl: button sync, game tick, jump sequencing and score.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dino_game_ctrl #(
  parameter int TICK_DIV  = 251250,
  parameter int JUMP_LEN  = 51,
  parameter int SCORE_DIV = 10,
  parameter int SCORE_W   = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn,
  input  logic               collision,
  output logic               halt,
  output logic [5:0]         jump_idx,
  output logic               jumping,
  output logic               tick,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
);

  localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_SDIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_SDIV_W-1:0] c_SDIV_LAST = c_SDIV_W'(SCORE_DIV - 1);
  localparam logic [5:0]          c_JUMP_LAST = 6'(JUMP_LEN - 1);
  localparam logic [SCORE_W-1:0]  c_SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JUMP = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_halt;
  logic                 r_jumping;
  logic [5:0]           r_jump_idx;
  logic                 r_btn_s1;
  logic                 r_btn_s2;
  logic                 r_btn_prev;
  logic [c_TICK_W-1:0]  r_tick_cnt;
  logic [c_SDIV_W-1:0]  r_score_sub;
  logic [SCORE_W-1:0]   r_score;
  logic                 w_btn_rise;
  logic                 w_active;
  logic                 w_tick;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_s1   <= btn;
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= r_btn_s2;
    end
  end

  assign w_btn_rise = r_btn_s2 & ~r_btn_prev;
  assign w_active   = (r_state == RUN) || (r_state == JUMP);
  assign w_tick     = w_active && (r_tick_cnt == c_TICK_LAST);

  // Counter sits at 0 in IDLE so every run starts a full tick period late.
  always_ff @(posedge clk) begin
    if (reset || (r_state == IDLE)) begin
      r_tick_cnt <= '0;
    end else if (w_active) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_TICK_W'(1);
    end else if (w_btn_rise) begin
      r_tick_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_score_sub <= '0;
      r_score     <= '0;
    end else if ((r_state == IDLE) && w_btn_rise) begin
      r_score_sub <= '0;
      r_score     <= '0;
    end else if (w_tick && !collision) begin
      if (r_score_sub == c_SDIV_LAST) begin
        r_score_sub <= '0;
        if (r_score != c_SCORE_MAX) begin
          r_score <= r_score + SCORE_W'(1);
        end
      end else begin
        r_score_sub <= r_score_sub + c_SDIV_W'(1);
      end
    end
  end

  // halt/jumping are updated together with the state so they never lag it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_halt     <= 1'b1;
      r_jumping  <= 1'b0;
      r_jump_idx <= 6'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_btn_rise) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
          end
        end
        RUN: begin
          if (collision) begin
            r_state <= OVER;
            r_halt  <= 1'b1;
          end else if (w_btn_rise) begin
            r_state    <= JUMP;
            r_jumping  <= 1'b1;
            r_jump_idx <= 6'd0;
          end
        end
        JUMP: begin
          if (collision) begin
            r_state   <= OVER;
            r_halt    <= 1'b1;
            r_jumping <= 1'b0;
          end else if (w_tick) begin
            if (r_jump_idx >= c_JUMP_LAST) begin
              r_state    <= RUN;
              r_jumping  <= 1'b0;
              r_jump_idx <= 6'd0;
            end else begin
              r_jump_idx <= r_jump_idx + 6'd1;
            end
          end
        end
        OVER: begin
          if (w_btn_rise) begin
            r_state    <= IDLE;
            r_jump_idx <= 6'd0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_halt     <= 1'b1;
          r_jumping  <= 1'b0;
          r_jump_idx <= 6'd0;
        end
      endcase
    end
  end

  assign state    = r_state;
  assign halt     = r_halt;
  assign jumping  = r_jumping;
  assign jump_idx = r_jump_idx;
  assign tick     = w_tick;
  assign score    = r_score;

endmodule
`default_nettype wire

// File: tb/tb_dino_game_ctrl.sv
`default_nettype none
// Bench for dino_game_ctrl: scoreboard of expected state transitions plus
// directed timing checks, with small parameters for short runs.
module tb_dino_game_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int JUMP_LEN  = 5;
  localparam int SCORE_DIV = 2;
  localparam int SCORE_W   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               btn = 1'b0;
  logic               collision = 1'b0;
  logic               halt;
  logic [5:0]         jump_idx;
  logic               jumping;
  logic               tick;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       hlt;
    logic       jmp;
    logic [5:0] idx;
    logic [3:0] scr;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic       mon_en = 1'b0;
  logic [1:0] last_state = 2'd0;

  always #5 clk = ~clk;

  dino_game_ctrl #(
    .TICK_DIV (TICK_DIV),
    .JUMP_LEN (JUMP_LEN),
    .SCORE_DIV(SCORE_DIV),
    .SCORE_W  (SCORE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .collision(collision),
    .halt     (halt),
    .jump_idx (jump_idx),
    .jumping  (jumping),
    .tick     (tick),
    .score    (score),
    .state    (state)
  );

  function automatic exp_t mk(logic [1:0] st, logic h, logic j, logic [5:0] i, logic [3:0] s);
    return exp_t'({st, h, j, i, s});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every observed state change must match the next queued entry.
  always @(negedge clk) begin
    if (mon_en && (state !== last_state)) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: state %0d appeared with nothing expected", state);
      end else begin
        mon_e = sb_q.pop_front();
        if ({state, halt, jumping, jump_idx, score} !== mon_e) begin
          fails++;
          $display("FAIL sb_transition: got st=%0d halt=%0d jumping=%0d idx=%0d score=%0d, expected st=%0d halt=%0d jumping=%0d idx=%0d score=%0d",
                   state, halt, jumping, jump_idx, score,
                   mon_e.st, mon_e.hlt, mon_e.jmp, mon_e.idx, mon_e.scr);
        end
      end
    end
    if (mon_en) last_state = state;
  end

  // Pulse btn for one cycle and count cycles until the target state shows up.
  task automatic press_wait(input logic [1:0] target, input string name);
    int n;
    n = 0;
    @(negedge clk);
    btn = 1'b1;
    do begin
      @(negedge clk);
      btn = 1'b0;
      n++;
    end while ((state !== target) && (n < 12));
    tests++;
    if ((state !== target) || (n > 3)) begin
      fails++;
      $display("FAIL %s: state %0d after %0d cycles, expected state %0d within 3", name, state, n, target);
    end
  endtask

  task automatic press_only();
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tick !== 1'b1) && (n < 20));
    if (tick !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no tick within %0d cycles, expected one", n);
    end
  endtask

  task automatic wait_state(input logic [1:0] target, input string name);
    int n;
    n = 0;
    while ((state !== target) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check(name, state, target);
  endtask

  initial begin
    int n;
    int tcount;

    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_halt", halt, 1);
    check("rst_jumping", jumping, 0);
    check("rst_jump_idx", jump_idx, 0);
    check("rst_tick", tick, 0);
    check("rst_score", score, 0);
    last_state = state;
    mon_en = 1'b1;
    reset = 1'b0;

    // Start a run and measure tick timing.
    sb_q.push_back(mk(2'd1, 1'b0, 1'b0, 6'd0, 4'd0));
    press_wait(2'd1, "idle_to_run");
    check("run_halt", halt, 0);
    wait_tick(n);
    check("first_tick_cycle", n + 1, 4);
    wait_tick(n);
    check("tick_period", n, 4);
    @(negedge clk);
    check("score_after_2_ticks", score, 1);

    // Full jump, with a re-press at jump_idx 2 that must be ignored.
    sb_q.push_back(mk(2'd2, 1'b0, 1'b1, 6'd0, 4'd1));
    sb_q.push_back(mk(2'd1, 1'b0, 1'b0, 6'd0, 4'd4));
    press_wait(2'd2, "run_to_jump");
    for (int i = 0; i < JUMP_LEN; i++) begin
      if (i == 2) press_only();
      wait_tick(n);
      check("jump_idx_step", jump_idx, i);
      check("jumping_high", jumping, 1);
    end
    wait_state(2'd1, "jump_end_state");
    check("jump_end_idx", jump_idx, 0);
    check("jump_end_jumping", jumping, 0);

    // Collision on the tick at jump_idx 3.
    sb_q.push_back(mk(2'd2, 1'b0, 1'b1, 6'd0, 4'd4));
    press_wait(2'd2, "run_to_jump2");
    for (int i = 0; i < 3; i++) wait_tick(n);
    wait_tick(n);
    check("collide_idx", jump_idx, 3);
    sb_q.push_back(mk(2'd3, 1'b1, 1'b0, 6'd3, 4'd6));
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    tcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tick === 1'b1) tcount++;
    end
    check("over_no_ticks", tcount, 0);
    check("over_score", score, 6);
    check("over_idx", jump_idx, 3);
    check("over_halt", halt, 1);
    sb_q.push_back(mk(2'd0, 1'b1, 1'b0, 6'd0, 4'd6));
    press_wait(2'd0, "over_to_idle");
    sb_q.push_back(mk(2'd1, 1'b0, 1'b0, 6'd0, 4'd0));
    press_wait(2'd1, "idle_to_run2");
    check("restart_score", score, 0);

    // Score saturation.
    for (int i = 0; i < 10; i++) wait_tick(n);
    @(negedge clk);
    check("score_10_ticks", score, 5);
    for (int i = 0; i < 30; i++) wait_tick(n);
    @(negedge clk);
    check("score_40_ticks", score, 15);
    for (int i = 0; i < 8; i++) wait_tick(n);
    @(negedge clk);
    check("score_48_ticks", score, 15);

    // Reset in the middle of a jump.
    sb_q.push_back(mk(2'd2, 1'b0, 1'b1, 6'd0, 4'd15));
    press_wait(2'd2, "run_to_jump3");
    wait_tick(n);
    wait_tick(n);
    @(negedge clk);
    check("pre_reset_idx", jump_idx, 2);
    sb_q.push_back(mk(2'd0, 1'b1, 1'b0, 6'd0, 4'd0));
    reset = 1'b1;
    @(negedge clk);
    check("midjump_rst_state", state, 0);
    check("midjump_rst_idx", jump_idx, 0);
    check("midjump_rst_score", score, 0);
    check("midjump_rst_halt", halt, 1);
    check("midjump_rst_jumping", jumping, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dino_game_ctrl.md
DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 251250: clk cycles per game tick (10 ms at 25.125 MHz).
REQ-002 Parameter JUMP_LEN, default 51: number of entries in the jump height table.
REQ-003 Parameter SCORE_DIV, default 10: game ticks per score increment.
REQ-004 Parameter SCORE_W, default 14: score counter width.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 btn  in  1  raw jump/start button, asynchronous, active-high.
REQ-008 collision  in  1  obstacle-hit flag, synchronous to clk, level.
REQ-009 halt  out  1  freezes downstream scroll and animation blocks when high.
REQ-010 jump_idx  out  6  jump height table address, 0..JUMP_LEN-1.
REQ-011 jumping  out  1  high while a jump is in progress.
REQ-012 tick  out  1  one-cycle game tick pulse.
REQ-013 score  out  SCORE_W  current score.
REQ-014 state  out  2  IDLE=0, RUN=1, JUMP=2, OVER=3.

Function
REQ-015 btn shall pass through a 2-flop synchronizer; btn_rise is sync-high AND previous-sync-low, so 2-3 cycles of latency.
REQ-016 Tick counter shall count only in RUN/JUMP; tick=1 for one cycle when count==TICK_DIV-1, count then wraps to 0.
REQ-017 Tick counter shall hold its value in OVER, be 0 in IDLE, and be cleared on the IDLE->RUN transition.
REQ-018 IDLE: btn_rise -> RUN; score cleared to 0 on this transition.
REQ-019 RUN: btn_rise -> JUMP with jump_idx=0; collision -> OVER.
REQ-020 JUMP: each tick increments jump_idx; a tick while jump_idx==JUMP_LEN-1 -> RUN with jump_idx=0.
REQ-021 JUMP: btn_rise ignored (no re-trigger, no restart of jump_idx).
REQ-022 Collision shall take priority over btn_rise and tick in the same cycle: -> OVER, jump_idx held.
REQ-023 OVER: btn_rise -> IDLE with jump_idx=0; score held until the next IDLE->RUN transition.
REQ-024 A score sub-counter shall advance per tick in RUN/JUMP; at SCORE_DIV-1 it wraps to 0 and score increments.
REQ-025 Score shall saturate at 2^SCORE_W-1, with no wrap.
REQ-026 halt, jumping and state shall be registered: halt=1 in IDLE/OVER, jumping=1 in JUMP only, with both valid in the cycle the state changes.
REQ-027 jump_idx shall never exceed JUMP_LEN-1.

Reset
REQ-028 reset shall override all other inputs in the same cycle, at any time including mid-jump.
REQ-029 After reset: state=IDLE, halt=1, jumping=0, jump_idx=0, tick=0, score=0, all counters and synchronizer flops 0.

Verification (TICK_DIV=4, JUMP_LEN=5, SCORE_DIV=2, SCORE_W=4)
REQ-030 Reset, then btn pulse -> state=RUN within 3 cycles, halt=0, first tick 4 cycles after entry, tick period 4.
REQ-031 In RUN, btn pulse -> JUMP, jumping=1, jump_idx steps 0,1,2,3,4 on ticks; the 5th tick -> RUN, jump_idx=0, jumping=0.
REQ-032 btn re-pressed at jump_idx=2 -> no effect, jump completes on schedule.
REQ-033 collision asserted in the same cycle as a tick at jump_idx=3 -> OVER, halt=1, jump_idx=3, no further ticks, score frozen; btn -> IDLE, then btn -> RUN with score=0.
REQ-034 Run for 40 ticks -> score saturates at 15 and stays at 15.
REQ-035 reset asserted during JUMP at jump_idx=2 -> next cycle IDLE, jump_idx=0, score=0, halt=1.
